// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared constants and write-FSM state encoding for the SRAM framebuffer writer
package sram_pkg;
    localparam int SRAM_AW  = 18;
    localparam int SRAM_DW  = 16;
    localparam int SLOT_LEN = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } wr_state_e;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational head and occupancy count
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 36
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/sram_fb_writer.sv
// rtl/sram_fb_writer.sv - buffers producer writes and issues one 3-cycle SRAM write per reader slot
module sram_fb_writer
    import sram_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = SRAM_AW,
    parameter int DW    = SRAM_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    input  logic [1:0]               in_be,
    input  logic                     slot,
    output logic                     sram_own,
    output logic [AW-1:0]            sram_addr,
    output logic [DW-1:0]            sram_dq_o,
    output logic                     sram_dq_oe,
    output logic                     sram_we_n,
    output logic                     sram_ub_n,
    output logic                     sram_lb_n,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     idle
);
    localparam int WIDTH = AW + DW + 2;

    wr_state_e        state;
    logic [WIDTH-1:0] head;
    logic [AW-1:0]    head_addr;
    logic [DW-1:0]    head_data;
    logic [1:0]       head_be;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;

    assign head_addr = head[WIDTH-1 -: AW];
    assign head_data = head[DW+1 -: DW];
    assign head_be   = head[1:0];

    assign in_ready = ~fifo_full;
    assign fifo_pop = (state == SETUP);
    assign idle     = fifo_empty & (state == IDLE);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid & in_ready),
        .wdata ({in_addr, in_data, in_be}),
        .pop   (fifo_pop),
        .rdata (head),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Head is latched on entry to SETUP, so popping at SETUP->PULSE does not disturb the bus
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sram_own   <= 1'b0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (slot && !fifo_empty) begin
                        state      <= SETUP;
                        sram_own   <= 1'b1;
                        sram_dq_oe <= 1'b1;
                        sram_addr  <= head_addr;
                        sram_dq_o  <= head_data;
                        sram_ub_n  <= ~head_be[1];
                        sram_lb_n  <= ~head_be[0];
                    end
                end
                SETUP: begin
                    state     <= PULSE;
                    sram_we_n <= 1'b0;
                end
                PULSE: begin
                    state     <= HOLD;
                    sram_we_n <= 1'b1;
                end
                HOLD: begin
                    state      <= IDLE;
                    sram_own   <= 1'b0;
                    sram_dq_oe <= 1'b0;
                    sram_ub_n  <= 1'b1;
                    sram_lb_n  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_fb_writer.sv
// tb/tb_sram_fb_writer.sv - directed self-checking bench for sram_fb_writer
module tb_sram_fb_writer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_addr;
    logic [15:0] in_data;
    logic [1:0]  in_be;
    logic        slot;
    logic        sram_own;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;
    logic [3:0]  level;
    logic        idle;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_slot = -100;

    localparam logic [44:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 18'h0, 16'h0, 4'h0, 1'b1};
    logic [44:0] out_vec;
    assign out_vec = {in_ready, sram_own, sram_dq_oe, sram_we_n, sram_ub_n, sram_lb_n,
                      sram_addr, sram_dq_o, level, idle};

    sram_fb_writer #(.DEPTH(8), .AW(18), .DW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .in_be      (in_be),
        .slot       (slot),
        .sram_own   (sram_own),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n),
        .level      (level),
        .idle       (idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [17:0] a, input logic [15:0] d, input logic [1:0] be);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_be    = be;
        tick();
        in_valid = 1'b0;
    endtask

    // Raises slot for one cycle; the reader never spaces slots closer than 4 cycles
    task automatic slot_pulse;
        checks++;
        if (cyc - last_slot < 4) begin
            errors++;
            $display("FAIL slot_spacing got %0d cycles need >= 4", cyc - last_slot);
        end
        last_slot = cyc;
        slot = 1'b1;
        tick();
        slot = 1'b0;
    endtask

    task automatic run_slot(output logic [17:0] a, output logic [15:0] d,
                            output logic ub, output logic lb, output logic we);
        slot_pulse();
        tick();
        a  = sram_addr;
        d  = sram_dq_o;
        ub = sram_ub_n;
        lb = sram_lb_n;
        we = sram_we_n;
        tick();
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (out_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_values got %h exp %h", out_vec, RESET_VEC);
        end
    endtask

    task automatic test_single_write;
        push(18'h00123, 16'hBEEF, 2'b11);
        checks++;
        if (level !== 4'd1) begin errors++; $display("FAIL single_level_pre got %0d exp 1", level); end
        slot_pulse();
        checks++;
        if ({sram_own, sram_dq_oe, sram_we_n, sram_addr, sram_dq_o} !== {1'b1, 1'b1, 1'b1, 18'h00123, 16'hBEEF}) begin
            errors++;
            $display("FAIL single_setup got own=%b oe=%b we_n=%b addr=%h dq=%h exp 1 1 1 00123 beef",
                     sram_own, sram_dq_oe, sram_we_n, sram_addr, sram_dq_o);
        end
        tick();
        checks++;
        if ({sram_we_n, sram_addr, sram_dq_o, level} !== {1'b0, 18'h00123, 16'hBEEF, 4'd0}) begin
            errors++;
            $display("FAIL single_pulse got we_n=%b addr=%h dq=%h level=%0d exp 0 00123 beef 0",
                     sram_we_n, sram_addr, sram_dq_o, level);
        end
        tick();
        checks++;
        if ({sram_own, sram_dq_oe, sram_we_n, sram_addr, sram_dq_o} !== {1'b1, 1'b1, 1'b1, 18'h00123, 16'hBEEF}) begin
            errors++;
            $display("FAIL single_hold got own=%b oe=%b we_n=%b addr=%h dq=%h exp 1 1 1 00123 beef",
                     sram_own, sram_dq_oe, sram_we_n, sram_addr, sram_dq_o);
        end
        tick();
        checks++;
        if ({sram_own, sram_dq_oe, idle} !== 3'b001) begin
            errors++;
            $display("FAIL single_release got own=%b oe=%b idle=%b exp 0 0 1", sram_own, sram_dq_oe, idle);
        end
    endtask

    task automatic test_empty_slot;
        logic saw_bus = 1'b0;
        slot_pulse();
        for (int i = 0; i < 4; i++) begin
            if (sram_own !== 1'b0 || sram_we_n !== 1'b1) saw_bus = 1'b1;
            tick();
        end
        checks++;
        if (saw_bus !== 1'b0) begin
            errors++;
            $display("FAIL empty_slot got bus_activity=%b exp 0", saw_bus);
        end
    endtask

    task automatic test_fill_and_drain;
        logic [17:0] a;
        logic [15:0] d;
        logic ub, lb, we;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got %b exp 1", i, in_ready); end
            push(18'h00100 + 18'(i), 16'hA000 + 16'(i), 2'b11);
        end
        checks++;
        if ({level, in_ready} !== {4'd8, 1'b0}) begin
            errors++;
            $display("FAIL fill_full got level=%0d ready=%b exp 8 0", level, in_ready);
        end
        // A ninth request stays pending through the full-cycle pop without being taken
        in_valid = 1'b1;
        in_addr  = 18'h003FF;
        in_data  = 16'hDEAD;
        in_be    = 2'b11;
        tick();
        checks++;
        if (level !== 4'd8) begin errors++; $display("FAIL fill_holdoff got level=%0d exp 8", level); end
        slot_pulse();
        checks++;
        if ({sram_addr, sram_dq_o} !== {18'h00100, 16'hA000}) begin
            errors++;
            $display("FAIL fill_head got addr=%h dq=%h exp 00100 a000", sram_addr, sram_dq_o);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({level, in_ready, sram_we_n} !== {4'd7, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL fill_pop_full got level=%0d ready=%b we_n=%b exp 7 1 0", level, in_ready, sram_we_n);
        end
        tick();
        tick();
        for (int i = 1; i < 8; i++) begin
            run_slot(a, d, ub, lb, we);
            checks++;
            if ({a, d, we} !== {18'h00100 + 18'(i), 16'hA000 + 16'(i), 1'b0}) begin
                errors++;
                $display("FAIL drain_%0d got addr=%h dq=%h we_n=%b exp %h %h 0",
                         i, a, d, we, 18'h00100 + 18'(i), 16'hA000 + 16'(i));
            end
        end
        checks++;
        if ({level, idle} !== {4'd0, 1'b1}) begin
            errors++;
            $display("FAIL drain_empty got level=%0d idle=%b exp 0 1", level, idle);
        end
    endtask

    task automatic test_byte_enables;
        logic [17:0] a;
        logic [15:0] d;
        logic ub, lb, we;
        push(18'h00020, 16'h1234, 2'b01);
        run_slot(a, d, ub, lb, we);
        checks++;
        if ({ub, lb, we, d} !== {1'b1, 1'b0, 1'b0, 16'h1234}) begin
            errors++;
            $display("FAIL be_lower got ub_n=%b lb_n=%b we_n=%b dq=%h exp 1 0 0 1234", ub, lb, we, d);
        end
        push(18'h00021, 16'h5678, 2'b10);
        run_slot(a, d, ub, lb, we);
        checks++;
        if ({ub, lb, we} !== {1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL be_upper got ub_n=%b lb_n=%b we_n=%b exp 0 1 0", ub, lb, we);
        end
        push(18'h00022, 16'h9ABC, 2'b00);
        run_slot(a, d, ub, lb, we);
        checks++;
        if ({ub, lb, we, level} !== {1'b1, 1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL be_none got ub_n=%b lb_n=%b we_n=%b level=%0d exp 1 1 0 0", ub, lb, we, level);
        end
    endtask

    task automatic test_ordering;
        logic [17:0] a [3];
        logic [15:0] d;
        logic ub, lb, we;
        push(18'h00010, 16'h0010, 2'b11);
        push(18'h00011, 16'h0011, 2'b11);
        slot_pulse();
        // Push lands on the same edge as the pop, so occupancy stays at 2
        in_valid = 1'b1;
        in_addr  = 18'h00012;
        in_data  = 16'h0012;
        in_be    = 2'b11;
        tick();
        in_valid = 1'b0;
        a[0] = sram_addr;
        checks++;
        if ({level, sram_we_n} !== {4'd2, 1'b0}) begin
            errors++;
            $display("FAIL order_push_pop got level=%0d we_n=%b exp 2 0", level, sram_we_n);
        end
        tick();
        tick();
        tick();
        for (int i = 1; i < 3; i++) begin
            run_slot(a[i], d, ub, lb, we);
            tick();
        end
        checks++;
        if ({a[0], a[1], a[2]} !== {18'h00010, 18'h00011, 18'h00012}) begin
            errors++;
            $display("FAIL order_addrs got %h %h %h exp 00010 00011 00012", a[0], a[1], a[2]);
        end
    endtask

    task automatic test_reset_in_pulse;
        for (int i = 0; i < 4; i++) push(18'h00040 + 18'(i), 16'h4000 + 16'(i), 2'b11);
        slot_pulse();
        tick();
        checks++;
        if ({sram_we_n, level} !== {1'b0, 4'd3}) begin
            errors++;
            $display("FAIL rstpulse_pre got we_n=%b level=%0d exp 0 3", sram_we_n, level);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL rstpulse_values got %h exp %h", out_vec, RESET_VEC);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        in_be    = 2'b00;
        slot     = 1'b0;
        test_reset();
        test_single_write();
        test_empty_slot();
        test_fill_and_drain();
        test_byte_enables();
        test_ordering();
        test_reset_in_pulse();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_fb_writer.md
Name: sram_fb_writer

Overview:
- Write-side counterpart to the SXGA scan-out reader on the shared 256Kx16 async SRAM.
- Accepts pixel/word write requests from a producer (UART loader, blitter) through a valid/ready handshake.
- Buffers requests in a small FIFO and performs 3-cycle SRAM write cycles only inside slots granted by the video reader.
- Runs on the 108 MHz pixel clock. The top-level mux selects this block's SRAM drive while sram_own=1.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, range 2..64.
- AW, 18, SRAM word address width.
- DW, 16, SRAM data width.

Ports:
- clk  in  1  108 MHz clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  producer has a write request.
- in_ready  out  1  FIFO can accept the request.
- in_addr  in  AW  word address.
- in_data  in  DW  write data.
- in_be  in  2  byte enables: [1]=upper byte, [0]=lower byte.
- slot  in  1  one-cycle pulse from the reader; grants the SRAM for the next 3 cycles.
- sram_own  out  1  this block drives the SRAM bus (selects the top-level mux).
- sram_addr  out  AW  SRAM address.
- sram_dq_o  out  DW  SRAM write data.
- sram_dq_oe  out  1  tri-state enable for sram_dq.
- sram_we_n  out  1  SRAM write strobe, active low.
- sram_ub_n  out  1  SRAM upper-byte enable, active low.
- sram_lb_n  out  1  SRAM lower-byte enable, active low.
- level  out  log2(DEPTH)+1  FIFO occupancy.
- idle  out  1  FIFO empty and FSM in IDLE.

Behaviour:
- Reset values: in_ready=1, sram_own=0, sram_dq_oe=0, sram_we_n=1, sram_ub_n=1, sram_lb_n=1, sram_addr=0, sram_dq_o=0, level=0, idle=1.
- Reset mid-write: the FSM returns to IDLE and the FIFO is emptied. The in-progress write may be left incomplete.
- FIFO:
  - Push when in_valid & in_ready. in_ready = (level != DEPTH), registered-free combinational.
  - Pop at the transition SETUP->PULSE.
  - Simultaneous push and pop when full: pop frees an entry, but in_ready stays 0 that cycle (in_ready is not a function of the pop).
  - Simultaneous push and pop when non-full: level is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, SETUP, PULSE, HOLD.
  - IDLE: if slot=1 and level!=0, go to SETUP next cycle; otherwise stay. A slot with an empty FIFO is forfeited.
  - SETUP, one cycle:
    - sram_own=1, sram_dq_oe=1, we_n=1.
    - addr, data and ub_n/lb_n are driven from the FIFO head (~in_be).
  - PULSE, one cycle: we_n=0; addr, data and byte enables held.
  - HOLD, one cycle:
    - we_n=1; data, oe and addr held for hold time.
    - Then go to IDLE, with sram_own=0 and oe=0 on the next edge.
- All SRAM-side outputs are registered.
- Exactly one write per slot. Latency from slot pulse to we_n falling edge is 2 cycles.
- A slot arriving while not in IDLE is ignored. The reader guarantees slot spacing of at least 4 cycles, and the bench asserts this.
- in_be=2'b00: the entry is still consumed. A full cycle is run with ub_n=lb_n=1 and no data is written.
- idle = (level==0) & (state==IDLE).

Decomposition:
- Package sram_pkg: FSM state enum (IDLE/SETUP/PULSE/HOLD); constants SRAM_AW=18, SRAM_DW=16, SLOT_LEN=3.
- Sub-module sync_fifo (DEPTH, WIDTH = AW+DW+2), with push/pop/level/full/empty. Head data is valid combinationally.

Test Plan:
- Single write: after reset, push addr=0x00123 data=0xBEEF be=2'b11, then slot pulse at cycle t.
  - Expected: SETUP at t+1; we_n=0 only at t+2; addr=0x00123 and dq_o=0xBEEF stable over t+1..t+3.
  - Expected: sram_own=0 at t+4; level 1->0.
- Slot with empty FIFO: slot pulse with level=0 -> sram_own stays 0 and we_n stays 1.
- Fill to full: push 8 entries with no slots.
  - Expected: in_ready=0 after the 8th push; a 9th in_valid is held off.
  - Then one slot -> entry 0 is written, level=7, in_ready=1.
- Byte enables: push be=2'b01 data=0x1234, then slot -> lb_n=0, ub_n=1 during the cycle. Then be=2'b00 -> both 1, and the entry is popped.
- Ordering: push addresses 0x10,0x11,0x12 with 3 slots spaced 5 cycles apart -> SRAM writes occur in order 0x10,0x11,0x12.
- Reset in PULSE: assert rst during PULSE with level=3 -> the next cycle shows all outputs at reset values, level=0, idle=1.
